// File: rtl/multicycle_core_ctrl.sv
// Multi-cycle RV32 control sequencer: owns PC/IR and steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB with req/ack memory handshakes, access timeout and sticky HALT/ERR.
module multicycle_core_ctrl #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     TIMEOUT  = 255,
  parameter int unsigned     CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rstd,
  output logic             imem_req,
  output logic [XLEN-1:0]  imem_addr,
  input  logic [31:0]      imem_rdata,
  input  logic             imem_ack,
  input  logic             is_load,
  input  logic             is_store,
  input  logic             is_halt,
  input  logic             reg_we,
  input  logic [XLEN-1:0]  nextpc,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic [XLEN-1:0]  pc,
  output logic [31:0]      ir,
  output logic             rf_wren,
  output logic [2:0]       state,
  output logic             halted,
  output logic             bus_err,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_ERR    = 3'd6
  } state_t;

  localparam logic [31:0]       NOP_INSN  = 32'h0000_0013;
  localparam int unsigned       WCNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam bit                TO_EN     = (TIMEOUT != 0);

  state_t            state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [31:0]       ir_q, ir_d;
  logic [CNT_W-1:0]  instret_q, instret_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              timeout_hit;
  logic              misaligned;

  // The ack of the TIMEOUT-th wait cycle is checked first, so it wins over the error.
  assign timeout_hit = TO_EN && (wcnt_q == WCNT_LAST);
  assign misaligned  = |nextpc[1:0];

  always_ff @(posedge clk or posedge rstd) begin
    if (rstd) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= NOP_INSN;
      instret_q <= '0;
      wcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      instret_q <= instret_d;
      wcnt_q    <= wcnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    instret_d = instret_q;
    wcnt_d    = wcnt_q;
    case (state_q)
      S_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          state_d = S_DECODE;
        end else if (timeout_hit) begin
          state_d = S_ERR;
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end
      S_DECODE: state_d = is_halt ? S_HALT : S_EXEC;
      S_EXEC:   state_d = (is_load || is_store) ? S_MEM : S_WB;
      S_MEM: begin
        if (dmem_ack) begin
          state_d = S_WB;
        end else if (timeout_hit) begin
          state_d = S_ERR;
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end
      S_WB: begin
        if (misaligned) begin
          state_d = S_ERR;
        end else begin
          pc_d      = nextpc;
          instret_d = instret_q + CNT_W'(1);
          state_d   = S_FETCH;
        end
      end
      S_HALT, S_ERR: state_d = state_q;
      default:       state_d = S_ERR;
    endcase
    if (state_d != state_q) wcnt_d = '0;
  end

  assign imem_req  = (state_q == S_FETCH);
  assign imem_addr = pc_q;
  assign dmem_req  = (state_q == S_MEM);
  assign dmem_we   = dmem_req && is_store;
  assign rf_wren   = (state_q == S_WB) && reg_we && !is_store && !misaligned;
  assign state     = state_q;
  assign halted    = (state_q == S_HALT) || (state_q == S_ERR);
  assign bus_err   = (state_q == S_ERR);
  assign pc        = pc_q;
  assign ir        = ir_q;
  assign instret   = instret_q;

endmodule

// File: doc/multicycle_core_ctrl.md
Name: multicycle_core_ctrl

Overview:
- Multi-cycle control sequencer for the RV32 core; successor to the single-cycle top-level datapath glue.
- Owns the PC and IR registers and steps each instruction through FETCH, DECODE, EXEC, MEM and WB.
- Uses req/ack handshakes to variable-latency instruction and data memories, with a per-access timeout, a retired-instruction counter and sticky halt/error states.
- Sits between the fetch/memory ports and the existing decoder, execution and reg_file blocks.

Parameters:
- XLEN, 32, PC and address width.
- RESET_PC, 0, PC value loaded on reset.
- TIMEOUT, 255, maximum wait cycles for an ack before bus error; 0 disables the timeout.
- CNT_W, 32, width of the instret counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rstd  in  1  asynchronous, active-high reset.
- imem_req  out  1  instruction fetch request; high for the whole FETCH state.
- imem_addr  out  XLEN  fetch address; equals pc.
- imem_rdata  in  32  instruction word; valid when imem_ack=1.
- imem_ack  in  1  fetch complete.
- is_load  in  1  from decoder.
- is_store  in  1  from decoder.
- is_halt  in  1  from decoder.
- reg_we  in  1  from decoder.
- nextpc  in  XLEN  from execution.
- dmem_req  out  1  data access request; high for the whole MEM state.
- dmem_we  out  1  equals is_store during MEM, else 0.
- dmem_ack  in  1  data access complete.
- pc  out  XLEN  current instruction address.
- ir  out  32  latched instruction.
- rf_wren  out  1  register-file write strobe; one-cycle pulse in WB.
- state  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, ERR=6.
- halted  out  1  high in HALT or ERR.
- bus_err  out  1  high only in ERR.
- instret  out  CNT_W  retired-instruction count.

Behaviour:
- Reset (async, immediate on rstd=1): state=FETCH, pc=RESET_PC, ir=32'h00000013 (NOP), instret=0, wait counter=0.
  - Outputs during reset: imem_req=1 (state decode), dmem_req=0, dmem_we=0, rf_wren=0, halted=0, bus_err=0.
  - Reset asserted mid-access abandons the access; no retire, no write.
- All outputs except imem_addr are decodes of registered state; no combinational path from ack inputs to outputs.
- FETCH: imem_req=1.
  - If imem_ack=1: ir<=imem_rdata, go to DECODE.
  - Else wait counter increments; if TIMEOUT!=0 and counter reaches TIMEOUT, go to ERR.
- DECODE: one cycle. If is_halt, go to HALT; else go to EXEC.
- EXEC: one cycle. If is_load|is_store, go to MEM; else go to WB.
- MEM: dmem_req=1, dmem_we=is_store.
  - If dmem_ack=1, go to WB.
  - Timeout rule is identical to FETCH.
- WB:
  - rf_wren = reg_we & ~is_store.
  - instret <= instret+1, wrapping modulo 2^CNT_W.
  - If nextpc[1:0]!=0 (misaligned target), go to ERR with pc unchanged and no retire.
  - Else pc<=nextpc and go to FETCH.
- Misaligned WB: rf_wren=0; the misaligned check overrides the write.
- HALT and ERR: sticky until reset. No requests are issued. pc, ir and instret are frozen.
- Wait counter: cleared on every state entry. An ack arriving in the same cycle the counter hits TIMEOUT wins (normal transition, no error).
- Ack outside the matching request state: ignored.
- Latency:
  - Minimum CPI is 4 (ack in the first FETCH cycle, non-memory instruction).
  - Loads and stores take 5 + memory wait cycles.
  - Each extra ack-wait cycle adds 1.
- Decoder inputs are sampled combinationally from ir in the DECODE, EXEC, MEM and WB states; the upstream decoder must be stable from ir.

Test Plan:
- Reset with RESET_PC=0x100, imem_ack always 1, ADDI program at 0x100 (nextpc=pc+4) → state sequence 0,1,2,4,0; pc=0x104 after 4 cycles; rf_wren pulses once; instret=1.
- Load with dmem_ack delayed 3 cycles → MEM lasts 4 cycles; dmem_req=1 and dmem_we=0 throughout; total 8 cycles; one rf_wren pulse.
- Store (reg_we=1 asserted erroneously) → dmem_we=1 in MEM; rf_wren stays 0; instret increments.
- TIMEOUT=4, imem_ack held 0 → ERR after 4 FETCH-wait cycles; bus_err=1, halted=1; pc unchanged; further acks ignored.
- Ack arrives exactly on the TIMEOUT cycle → DECODE, no error. Separately, is_halt=1 → HALT after DECODE, halted=1, bus_err=0, imem_req stays 0.
- nextpc=0x102 in WB → ERR, pc holds the old value, instret unchanged. rstd pulse mid-MEM → immediate FETCH, pc=RESET_PC, dmem_req=0 in the same cycle.
